// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared constants and FSM state type for the UART TX arbiter.
//   MAX_REQ     - largest supported requester count
//   BYTE_W      - transmitter byte width
//   arb_state_e - arbiter FSM state (IDLE, SEND, WAIT_BUSY, WAIT_DONE)
package uart_arb_pkg;

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned BYTE_W  = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req_i     [NUM_REQ-1:0] candidate requests
//   ptr_i     [IDW-1:0]     last granted index; search starts at ptr_i+1 with wrap
//   gnt_o     [NUM_REQ-1:0] one-hot grant
//   gnt_idx_o [IDW-1:0]     index of granted request
//   any_gnt_o               some request was granted
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDW-1:0]     gnt_idx_o,
  output logic               any_gnt_o
);

  // One extra bit so ptr+k (at most 2*NUM_REQ-1) never overflows before the wrap.
  logic [IDW:0] cand;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_gnt_o = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, ptr_i} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NUM_REQ)) begin
        cand = cand - (IDW+1)'(NUM_REQ);
      end
      if (!any_gnt_o && req_i[cand[IDW-1:0]]) begin
        any_gnt_o                = 1'b1;
        gnt_idx_o                = cand[IDW-1:0];
        gnt_o[cand[IDW-1:0]]     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one async transmitter byte channel between NUM_REQ
// valid/ready requesters, granting round-robin one byte at a time and waiting
// out the transmitter busy period before the next grant.
//   clk, rst_n   clock; synchronous active-low reset
//   req_valid    per-requester byte offer
//   req_data     requester i byte at [8i+7:8i]
//   req_last     byte ends requester packet (lock feature only)
//   req_ready    one-hot accept, only in IDLE
//   tx_start     one-cycle start pulse to transmitter (registered)
//   tx_data      byte to transmitter (registered)
//   tx_busy      transmitter busy
//   grant_id     requester owning the current/last byte
//   grant_valid  byte in flight (SEND..WAIT_DONE)
//   arb_busy     FSM not in IDLE
// Optional: define UART_TX_ARB_PACKET_LOCK_EN to keep the grant on one
// requester until it delivers a byte with req_last set.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_start,
  output logic [BYTE_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [IDW-1:0]            grant_id,
  output logic                      grant_valid,
  output logic                      arb_busy
);

  arb_state_e         state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     grant_id_q, grant_id_d;
  logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               grant_valid_q, grant_valid_d;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     gnt_idx;
  logic               any_gnt;
  logic               accept;

`ifdef UART_TX_ARB_PACKET_LOCK_EN
  logic           lock_q, lock_d;
  logic [IDW-1:0] lock_id_q, lock_id_d;

  // While locked only the owner may win, even when its valid is low.
  always_comb begin
    eligible = req_valid;
    if (lock_q) begin
      eligible            = '0;
      eligible[lock_id_q] = req_valid[lock_id_q];
    end
  end
`else
  logic unused_req_last;
  assign unused_req_last = ^req_last;
  assign eligible        = req_valid;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i     (eligible),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_gnt_o (any_gnt)
  );

  assign accept    = (state_q == IDLE) && !tx_busy && any_gnt;
  assign req_ready = accept ? gnt : '0;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_id_d    = grant_id_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    grant_valid_d = grant_valid_q;
`ifdef UART_TX_ARB_PACKET_LOCK_EN
    lock_d        = lock_q;
    lock_id_d     = lock_id_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          tx_data_d     = req_data[gnt_idx*BYTE_W +: BYTE_W];
          grant_id_d    = gnt_idx;
          ptr_d         = gnt_idx;
          tx_start_d    = 1'b1;
          grant_valid_d = 1'b1;
          state_d       = SEND;
`ifdef UART_TX_ARB_PACKET_LOCK_EN
          // Non-last byte opens/keeps the lock; last byte releases it.
          lock_d        = !req_last[gnt_idx];
          lock_id_d     = gnt_idx;
`endif
        end
      end
      SEND:      state_d = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d       = IDLE;
          grant_valid_d = 1'b0;
        end
      end
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= IDW'(NUM_REQ - 1);
      grant_id_q    <= '0;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      grant_valid_q <= 1'b0;
`ifdef UART_TX_ARB_PACKET_LOCK_EN
      lock_q        <= 1'b0;
      lock_id_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_id_q    <= grant_id_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      grant_valid_q <= grant_valid_d;
`ifdef UART_TX_ARB_PACKET_LOCK_EN
      lock_q        <= lock_d;
      lock_id_q     <= lock_id_d;
`endif
    end
  end

  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;
  assign grant_valid = grant_valid_q;
  assign arb_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NUM_REQ=4) with a simple
// transmitter model that stays busy FRAME cycles after each start.
module tb_uart_tx_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned FRAME = 10;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]  req_last;
  logic [N-1:0]  req_ready;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_busy;
  logic [1:0]    grant_id;
  logic          grant_valid;
  logic          arb_busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  data;
    int unsigned id;
  } exp_t;
  exp_t sb[$];

  int unsigned busy_cnt = 0;
  logic        force_busy = 1'b0;

  uart_tx_arbiter #(.NUM_REQ(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .arb_busy    (arb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter model: unaffected by the arbiter reset.
  always @(posedge clk) begin
    if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    else if (tx_start) busy_cnt <= FRAME;
  end
  assign tx_busy = (busy_cnt != 0) || force_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  // Scoreboard pop on every start pulse.
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_start observed=%0h expected=none", tx_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("tx_data", {24'b0, tx_data}, {24'b0, e.data});
        chk("grant_id", {30'b0, grant_id}, e.id);
        chk("busy_at_start", {31'b0, tx_busy}, 32'd0);
        chk("grant_valid_send", {31'b0, grant_valid}, 32'd1);
      end
    end
  end

  task automatic wait_ready(input int unsigned i, input string tag);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (req_ready[i] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout(tag);
    else chk(tag, {28'b0, req_ready}, 32'(1 << i));
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!arb_busy && !tx_busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout(tag);
    else chk({tag, "_sb_empty"}, sb.size(), 32'd0);
  endtask

  task automatic wait_busy_level(input logic lvl, input string tag);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (tx_busy === lvl) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout(tag);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [N-1:0] rdy;
  bit           got;

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_arb_busy", {31'b0, arb_busy}, 32'd0);
    chk("rst_tx_start", {31'b0, tx_start}, 32'd0);
    chk("rst_tx_data", {24'b0, tx_data}, 32'd0);
    chk("rst_grant_id", {30'b0, grant_id}, 32'd0);
    chk("rst_grant_valid", {31'b0, grant_valid}, 32'd0);
    chk("rst_ready", {28'b0, req_ready}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single byte, then spacing to the next accept
    sb.push_back('{data: 8'hA5, id: 0});
    req_data[7:0] = 8'hA5;
    req_valid     = 4'b0001;
    wait_ready(0, "single_ready");
    @(posedge clk); #1;
    req_valid      = 4'b0010;
    req_data[15:8] = 8'h3C;
    sb.push_back('{data: 8'h3C, id: 1});
    @(negedge clk);
    chk("start_latency", {31'b0, tx_start}, 32'd1);
    wait_busy_level(1'b1, "busy_rise");
    wait_busy_level(1'b0, "busy_fall");
    chk("ready_at_busy_fall", {28'b0, req_ready}, 32'd0);
    chk("arb_busy_at_busy_fall", {31'b0, arb_busy}, 32'd1);
    @(negedge clk);
    chk("ready_after_busy_fall", {28'b0, req_ready}, 32'b0010);
    @(posedge clk); #1 req_valid = '0;
    wait_idle("single_idle");

    // Fairness from reset pointer
    do_reset();
    req_data = {8'h43, 8'h32, 8'h21, 8'h10};
    sb.push_back('{data: 8'h10, id: 0});
    sb.push_back('{data: 8'h21, id: 1});
    sb.push_back('{data: 8'h32, id: 2});
    sb.push_back('{data: 8'h43, id: 3});
    sb.push_back('{data: 8'h10, id: 0});
    req_valid = 4'b1111;
    got = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) timeout("fair_drain");
    @(posedge clk); #1 req_valid = '0;
    wait_idle("fair_idle");

    // Busy high across reset exit
    @(posedge clk); #1;
    rst_n      = 1'b0;
    force_busy = 1'b1;
    req_data   = {16'h0, 8'h88, 8'h77};
    req_valid  = 4'b0011;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("busy_rst_ready", {28'b0, req_ready}, 32'd0);
      chk("busy_rst_start", {31'b0, tx_start}, 32'd0);
    end
    @(posedge clk); #1;
    sb.push_back('{data: 8'h77, id: 0});
    force_busy = 1'b0;
    wait_ready(0, "busy_rst_ready0");
    @(posedge clk); #1 req_valid = 4'b0010;

    // Reset during WAIT_DONE
    wait_busy_level(1'b1, "mid_busy_rise");
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.push_back('{data: 8'h88, id: 1});
    @(negedge clk);
    chk("mid_pre_arb_busy", {31'b0, arb_busy}, 32'd1);
    @(negedge clk);
    chk("mid_rst_arb_busy", {31'b0, arb_busy}, 32'd0);
    chk("mid_rst_grant_valid", {31'b0, grant_valid}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_ready_while_busy", {28'b0, req_ready}, 32'd0);
    wait_ready(1, "mid_ready1");
    @(posedge clk); #1 req_valid = '0;
    wait_idle("mid_idle");
    repeat (5) @(negedge clk);

    // Packet lock stimulus
    do_reset();
    req_data  = {16'h0, 8'h55, 8'h01};
    req_last  = 4'b1110;
    req_valid = 4'b0011;
`ifdef UART_TX_ARB_PACKET_LOCK_EN
    sb.push_back('{data: 8'h01, id: 0});
    sb.push_back('{data: 8'h02, id: 0});
    sb.push_back('{data: 8'h55, id: 1});
`else
    sb.push_back('{data: 8'h01, id: 0});
    sb.push_back('{data: 8'h55, id: 1});
    sb.push_back('{data: 8'h02, id: 0});
`endif
    for (int k = 0; k < 3; k++) begin
      got = 1'b0;
      rdy = '0;
      for (int n = 0; n < 300; n++) begin
        @(negedge clk);
        if (|req_ready) begin
          got = 1'b1;
          rdy = req_ready;
          break;
        end
      end
      if (!got) begin
        timeout("lock_accept");
      end else begin
        chk("lock_onehot", $countones(rdy), 32'd1);
        @(posedge clk); #1;
        if (rdy[0]) begin
          if (req_data[7:0] == 8'h01) begin
            req_data[7:0] = 8'h02;
            req_last[0]   = 1'b1;
          end else begin
            req_valid[0] = 1'b0;
          end
        end else begin
          req_valid[1] = 1'b0;
        end
      end
    end
    req_valid = '0;
    wait_idle("lock_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
